// File: rtl/mips32_fetch_unit.sv
// mips32_fetch_unit: instruction fetch front-end for the MIPS32 pipeline.
// Issues word-addressed reads to a 1-cycle-latency instruction memory,
// buffers {pc, instr} pairs in a small FIFO, and presents the FIFO head to
// decode over a valid/ready handshake. Branch redirects flush the FIFO and
// discard the in-flight read; a captured HLT word stops further fetching.
module mips32_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [31:0]                  imem_rdata,
  output logic                         id_valid,
  output logic [31:0]                  id_instr,
  output logic [31:0]                  id_pc,
  input  logic                         id_ready,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         halted,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int          PTR_W  = $clog2(DEPTH);
  localparam int          CNT_W  = $clog2(DEPTH+1);
  localparam logic [5:0]  HLT_OP = 6'b111111;

  logic [31:0]      pc;
  logic [31:0]      req_pc;      // PC of the read currently in flight
  logic             pending;     // a read was issued last cycle
  logic             stop;        // HLT captured; no more fetching
  logic             halted_q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];

  logic             redirect_act;
  logic [CNT_W:0]   inflight;
  logic             push;
  logic             pop;
  logic             hlt_push;
  logic             hlt_pop;

  // Redirects are ignored once halted; only reset leaves the halted state.
  assign redirect_act = redirect && !halted_q;

  // Pops are not credited here, so a full FIFO can never be overrun.
  assign inflight = {1'b0, count} + (CNT_W+1)'(pending);
  assign imem_req = !rst && !redirect && !stop && !halted_q &&
                    (inflight < (CNT_W+1)'(DEPTH));
  assign imem_addr = pc[ADDR_W-1:0];

  // Responses arriving after a HLT was captured are dropped.
  assign push     = pending && !redirect_act && !stop && !halted_q;
  assign hlt_push = push && (imem_rdata[31:26] == HLT_OP);

  assign id_valid = (count != '0) && !halted_q;
  assign id_instr = fifo_instr[head];
  assign id_pc    = fifo_pc[head];
  assign pop      = id_valid && id_ready;
  assign hlt_pop  = pop && (fifo_instr[head][31:26] == HLT_OP);

  assign halted    = halted_q;
  assign occupancy = count;

  // Fetch control: PC, in-flight tracking, FIFO pointers/count, stop and halt.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
      stop     <= 1'b0;
      halted_q <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_act) begin
      pc      <= redirect_pc;
      pending <= 1'b0;
      stop    <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      pending <= imem_req;
      if (imem_req) begin
        pc     <= pc + 32'd1;
        req_pc <= pc;
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (hlt_push) stop     <= 1'b1;
      if (hlt_pop)  halted_q <= 1'b1;
    end
  end

  // FIFO storage write of the returning word and its request PC.
  // NOTE: the storage array is deliberately not reset; count alone decides
  // which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[tail] <= imem_rdata;
      fifo_pc[tail]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// tb_mips32_fetch_unit: self-checking bench for mips32_fetch_unit. A cycle
// table covers reset and fetch latency; a scoreboard queue of expected
// {pc, instr} pairs checks ordered delivery through stalls, redirects,
// HLT and mid-stream reset.
module tb_mips32_fetch_unit;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam logic [31:0] HLT_WORD = 32'hFC00_0003;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = 32'h0;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic              id_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halted;
  logic [2:0]        occupancy;

  mips32_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory model: synchronous read, one cycle latency.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  int n_pass  = 0;
  int n_total = 0;
  int ovf_errs = 0;

  // FIFO must never report more than DEPTH entries.
  always @(negedge clk) begin
    if (occupancy > 3'(DEPTH)) ovf_errs++;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rst;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_occ;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = first + 32'(i);
      e.instr = mem[e.pc[ADDR_W-1:0]];
      sb.push_back(e);
    end
  endtask

  // Consume the scoreboard: decode stalls for `hold` cycles, then accepts
  // whenever something is still expected. Bounded by max_cycles.
  task automatic run_stream(input int hold, input int max_cycles);
    int cyc = 0;
    while (sb.size() != 0 && cyc < max_cycles) begin
      id_ready = (cyc >= hold);
      @(negedge clk);
      if (hold > 0 && cyc == hold - 1) begin
        check("stall_full_occ", 32'(occupancy), DEPTH);
        check("stall_no_req", 32'(imem_req), 0);
      end
      if (id_valid && id_ready) begin
        exp_t e = sb.pop_front();
        check("stream_pc", id_pc, e.pc);
        check("stream_instr", id_instr, e.instr);
      end
      tick();
      cyc++;
    end
    id_ready = 1'b0;
    check("stream_drained", 32'(sb.size()), 0);
  endtask

  // Reset then stall decode so the FIFO holds 3 entries with a read pending.
  task automatic reset_and_fill3();
    rst = 1'b1; id_ready = 1'b0; redirect = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2400_0000 | 32'(i);
    rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    tick();

    // Reset cycle then free run: first request in cycle 1, first valid in 3.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 3'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 3'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'd0, 3'd1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'd1, 3'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2, 3'd1};
    for (int r = 0; r < 6; r++) begin
      rst = vecs[r].rst;
      id_ready = vecs[r].ready;
      @(negedge clk);
      check($sformatf("t%0d_req", r), 32'(imem_req), 32'(vecs[r].exp_req));
      check($sformatf("t%0d_addr", r), 32'(imem_addr), vecs[r].exp_addr);
      check($sformatf("t%0d_valid", r), 32'(id_valid), 32'(vecs[r].exp_valid));
      check($sformatf("t%0d_occ", r), 32'(occupancy), 32'(vecs[r].exp_occ));
      check($sformatf("t%0d_halted", r), 32'(halted), 0);
      if (vecs[r].exp_valid) begin
        check($sformatf("t%0d_pc", r), id_pc, vecs[r].exp_pc);
        check($sformatf("t%0d_instr", r), id_instr, mem[vecs[r].exp_pc[ADDR_W-1:0]]);
      end
      tick();
    end
    push_exp(32'd3, 7);
    run_stream(0, 40);

    // Decode stalled 10 cycles: FIFO fills, requests stop, order preserved.
    push_exp(32'd10, 10);
    run_stream(10, 60);

    // Redirect with 3 entries buffered and a read pending.
    reset_and_fill3();
    @(negedge clk);
    check("redir_pre_occ", 32'(occupancy), 3);
    redirect = 1'b1; redirect_pc = 32'h20;
    @(negedge clk);
    check("redir_cycle_no_req", 32'(imem_req), 0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_r1_valid", 32'(id_valid), 0);
    check("redir_r1_req", 32'(imem_req), 1);
    check("redir_r1_addr", 32'(imem_addr), 32'h20);
    tick();
    id_ready = 1'b1;
    @(negedge clk);
    check("redir_r2_valid", 32'(id_valid), 0);
    tick();
    @(negedge clk);
    check("redir_r3_valid", 32'(id_valid), 1);
    check("redir_r3_pc", id_pc, 32'h20);
    check("redir_r3_instr", id_instr, mem[32'h20]);
    check("redir_r3_occ", 32'(occupancy), 1);
    tick();
    push_exp(32'h21, 4);
    run_stream(0, 30);

    // Reset mid-stream with 3 entries buffered.
    reset_and_fill3();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_no_req", 32'(imem_req), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_occ", 32'(occupancy), 0);
    check("mid_rst_valid", 32'(id_valid), 0);
    check("mid_rst_halted", 32'(halted), 0);
    check("mid_rst_req", 32'(imem_req), 1);
    check("mid_rst_addr", 32'(imem_addr), 0);
    tick();
    push_exp(32'd0, 4);
    run_stream(0, 30);

    // HLT at word 3: words 0..3 delivered, fetch stops, halted after pop.
    mem[3] = HLT_WORD;
    rst = 1'b1; id_ready = 1'b1;
    tick();
    rst = 1'b0;
    push_exp(32'd0, 3);
    run_stream(0, 30);
    id_ready = 1'b1;
    @(negedge clk);
    check("hlt_head_valid", 32'(id_valid), 1);
    check("hlt_head_pc", id_pc, 32'd3);
    check("hlt_head_instr", id_instr, HLT_WORD);
    check("hlt_stop_no_req", 32'(imem_req), 0);
    check("hlt_not_yet_halted", 32'(halted), 0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h50;
    @(negedge clk);
    check("halted_set", 32'(halted), 1);
    check("halted_valid", 32'(id_valid), 0);
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halted_stays", 32'(halted), 1);
      check("halted_no_req", 32'(imem_req), 0);
      check("halted_no_valid", 32'(id_valid), 0);
      tick();
    end

    // Redirect in the same cycle the HLT word returns.
    reset_and_fill3();
    @(negedge clk);
    check("hlt_redir_pre_occ", 32'(occupancy), 3);
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("hlt_redir_no_req", 32'(imem_req), 0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("hlt_redir_req", 32'(imem_req), 1);
    check("hlt_redir_addr", 32'(imem_addr), 32'h40);
    tick();
    push_exp(32'h40, 4);
    run_stream(0, 30);
    @(negedge clk);
    check("hlt_redir_not_halted", 32'(halted), 0);

    check("no_overflow", 32'(ovf_errs), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mips32_fetch_unit.md
# mips32_fetch_unit

Instruction fetch front-end for the MIPS32 five-stage pipeline. Issues word-addressed reads to a synchronous instruction memory and buffers returned words with their PC in a small FIFO. Hands them to the IF/ID boundary through a valid/ready handshake. Handles branch redirects by flushing the FIFO and discarding the in-flight read, and stops fetching once a HLT word (opcode 6'b111111) is captured.

## Interface
- DEPTH, 4: FIFO entries (power of two, ≥2).
- ADDR_W, 10: instruction memory word-address width (1024 words).
- RESET_PC, 0: PC loaded on reset.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address, pc[ADDR_W-1:0].
- imem_rdata  in  32  read data, valid in the cycle after the request cycle (fixed 1-cycle latency; memory never stalls).
- id_valid  out  1  FIFO head holds a valid instruction.
- id_instr  out  32  head instruction word.
- id_pc  out  32  head instruction PC.
- id_ready  in  1  decode accepts head this cycle.
- redirect  in  1  branch taken; discard everything younger.
- redirect_pc  in  32  new fetch PC.
- halted  out  1  HLT has been accepted by decode.
- occupancy  out  $clog2(DEPTH+1)  current FIFO count.

## Operation
- State: pc (32b), pending (1b, request issued last cycle), stop (1b), halted (1b), FIFO of {pc, instr} with count.
- Reset values: pc=RESET_PC, pending=0, stop=0, halted=0, count=0. Outputs during and after reset cycle: imem_req=0, id_valid=0, halted=0, occupancy=0.
- imem_req = !rst && !redirect && !stop && !halted && (count + pending < DEPTH). Combinational from registered state plus redirect. Pops are not credited, which makes the condition conservative and overflow impossible.
- On an issued request: pc <= pc+1 (word addressing, 32-bit wrap 0xFFFFFFFF→0); pending <= 1. Otherwise pending <= 0.
- Push: if pending and no redirect this cycle, write {pc_of_request, imem_rdata} at tail. If stop was already set, drop the word instead.
- Push of HLT (imem_rdata[31:26]==6'b111111) sets stop. Any response arriving after it is dropped.
- Pop: id_valid && id_ready. Popping a HLT word sets halted. Once halted, FIFO contents are frozen, id_valid=0, no requests are issued, and only rst clears halted.
- Redirect (priority over push, pop and issue): count<=0, pending response discarded, pc<=redirect_pc, stop<=0. No request in the redirect cycle. Ignored when halted=1.
- Push and pop in the same cycle: count unchanged, both occur.
- It is an error to push with count==DEPTH and no pop. The bench asserts this never happens.

## Timing
- Request in cycle n → data sampled at end of n+1 → id_valid=1 in n+2 (fetch-to-decode latency 2).
- After rst deasserts (rst high in cycle 0): first imem_req in cycle 1 with addr=RESET_PC; id_valid=1 in cycle 3.
- Steady state with id_ready=1: one instruction per cycle, occupancy settles at 1.
- Redirect in cycle r: id_valid=0 from r+1; request to redirect_pc in r+1; that word is at the head in r+3.
- id_ready=0: FIFO fills, and requests stop when count+pending reaches DEPTH. No word is lost or duplicated.
- halted rises the cycle after the HLT pop.

## Test plan
- Reset then free run, MEM[0..5]=distinct words, id_ready=1 → id_pc 0,1,2,… on consecutive cycles starting cycle 3, with instructions matching MEM.
- id_ready held 0 for 10 cycles → occupancy reaches 4, imem_req=0 while full, no overflow. Release → sequence continues in order with no gaps or duplicates.
- redirect with redirect_pc=0x20 while FIFO holds 3 entries and a read is pending → all 3 discarded, pending word dropped, next accepted id_pc=0x20 exactly 3 cycles later.
- HLT at MEM[3] → words 0–3 delivered, imem_req stays 0 after the HLT response, halted=1 the cycle after PC 3 is popped, id_valid=0 thereafter.
- redirect in the same cycle as a HLT push, before it is popped → stop cleared, fetch resumes at redirect_pc, halted stays 0.
- rst asserted mid-stream with FIFO at 3 entries → next cycle occupancy=0, id_valid=0, halted=0, then fetch restarts from RESET_PC.
